siso_frame_sched: RTL and testbench
===================================

# siso_frame_sched

Two-requester serial frame scheduler for the 4-stage serial-in/serial-out shift chain. It arbitrates round-robin between two parallel-word requesters and serialises the granted word LSB-first onto the chain's `d` input. It then holds the line low while the chain drains, and signals when the word's last bit has emerged at the chain output. It sits directly in front of the SISO chain: `sdo` drives the chain's `d`, and `clk`/`rst` are shared with it.

## Interface
- `WIDTH`, 4: bits per word; also the number of shift cycles per frame (≥1).
- `DEPTH`, 4: number of flop stages in the downstream serial chain (≥1).
- `clk`  in  1  rising-edge clock, shared with the SISO chain.
- `rst`  in  1  synchronous, active-high reset.
- `req0`  in  1  requester 0 has a word pending; held high until `grant0`.
- `data0`  in  WIDTH  requester 0 word; sampled on the edge ending the `grant0` cycle.
- `req1`  in  1  requester 1 request, same rules as `req0`.
- `data1`  in  WIDTH  requester 1 word, same rules as `data0`.
- `grant0`  out  1  one-cycle acceptance pulse for requester 0.
- `grant1`  out  1  one-cycle acceptance pulse for requester 1.
- `sdo`  out  1  serial data to the chain `d` input; registered.
- `sdo_vld`  out  1  high while `sdo` carries a word bit.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse in the cycle the last word bit is present at the chain output `q`.
- `owner`  out  1  index of the requester whose frame is in flight; holds its last value in IDLE.

## Operation
- FSM states are IDLE, SHIFT and FLUSH, with a bit/flush counter of width clog2(max(WIDTH,DEPTH))+1.
- **IDLE**
  - `grant*` is combinational.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester other than `last` (the round-robin pointer). Update `last` and `owner` to the granted index.
  - On that edge, load the shift register from the granted `data*`, clear the counter and go to SHIFT.
  - With no request, stay in IDLE.
- **SHIFT**
  - `sdo` = shreg[0] and `sdo_vld` = 1.
  - Each edge shifts shreg right by 1 and increments the counter.
  - After WIDTH SHIFT cycles, clear the counter and go to FLUSH.
- **FLUSH**
  - `sdo` = 0 and `sdo_vld` = 0.
  - The FSM stays in FLUSH for DEPTH cycles.
  - `done` = 1 in the final FLUSH cycle; the next edge returns to IDLE.
- Requests are ignored while `busy`; no grant is issued outside IDLE.
- Only the word latched at grant time is transmitted; changes to `data*` after grant have no effect.
- A request withdrawn before its grant is simply dropped; the arbiter has no memory of it.

## Timing
- **Reset** (edge with `rst`=1): state=IDLE, shreg=0, counter=0, `last`=1 (requester 0 wins the first tie), `owner`=0. `sdo`, `sdo_vld`, `busy` and `done` are all 0, and `grant*` is 0 during reset.
- **Reset mid-frame**: the frame is aborted and no `done` is issued. Outputs take their reset values from the cycle after the reset edge.
- **Frame timeline** (grant in cycle T):
  - `sdo` bit i is driven in cycle T+1+i, for i = 0..WIDTH-1.
  - FLUSH occupies cycles T+WIDTH+1 .. T+WIDTH+DEPTH.
  - `done` is high in cycle T+WIDTH+DEPTH, the cycle in which chain `q` carries bit WIDTH-1.
  - The earliest next grant is cycle T+WIDTH+DEPTH+1. The frame period is WIDTH+DEPTH+1 cycles (9 at defaults).
- **Latencies**:
  - Grant latency from a request in IDLE is 0 cycles.
  - Under continuous requests from both sides, grants strictly alternate, so the worst-case wait is one frame period.
- **Simultaneous events**:
  - `done` and a new request in the same cycle: no grant that cycle; the grant is issued in the following IDLE cycle.
  - `rst` and `req` in the same cycle: reset wins and no grant is issued.

## Test plan
- **Single frame**: reset, then `req0`=1 with `data0`=4'b1011 at cycle T.
  - Expect `grant0` only in cycle T.
  - Expect `sdo` = 1,1,0,1 in cycles T+1..T+4 with `sdo_vld`=1.
  - Expect `sdo`=0 for T+5..T+8, `done` only in T+8, and `busy` falling at T+9.
  - Chain `q` must show 1,1,0,1 in cycles T+5..T+8.
- **Tie after reset**: `req0`=`req1`=1, `data0`=4'hA, `data1`=4'h5, both held continuously.
  - Expect grants 0,1,0,1 at 9-cycle spacing, with `owner` tracking each grant.
  - Expect `sdo` bits of A (0,1,0,1), then 5 (1,0,1,0).
- **Busy masking**: `req1` asserted at T+2 during requester 0's frame.
  - Expect no grant until T+9, then `grant1` at T+9.
- **Mid-frame reset**: `rst`=1 for one cycle at T+3.
  - Expect `sdo`, `busy` and `done` all 0 from T+4.
  - Expect no `done` for the aborted frame.
  - Expect a fresh `req0` to be granted immediately afterwards.
- **Data change after grant**: `data0` changes 4'hF → 4'h0 at T+1.
  - Expect `sdo` = 1,1,1,1.
- **Parameter sweep**: WIDTH=8, DEPTH=2, `data0`=8'h96.
  - Expect `sdo` = 0,1,1,0,1,0,0,1 in T+1..T+8.
  - Expect `done` at T+10 and the next grant no earlier than T+11.

Source files
------------

// File: rtl/siso_frame_sched.sv
// Round-robin two-requester scheduler that serialises words LSB-first
// onto a SISO shift chain, then flushes the chain and flags completion.
module siso_frame_sched #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             grant0,
    output logic             grant1,
    output logic             sdo,
    output logic             sdo_vld,
    output logic             busy,
    output logic             done,
    output logic             owner
);

    localparam int MAXWD = (WIDTH > DEPTH) ? WIDTH : DEPTH;
    localparam int CW    = $clog2(MAXWD) + 1;
    localparam logic [CW-1:0] WLAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] DLAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FLUSH
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic             last;
    logic             last_nx;
    logic             owner_q;
    logic             owner_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            last    <= 1'b1;
            owner_q <= 1'b0;
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            cnt     <= cnt_nx;
            last    <= last_nx;
            owner_q <= owner_nx;
        end
    end

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        last_nx  = last;
        owner_nx = owner_q;
        grant0   = 1'b0;
        grant1   = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                // tie goes to whichever requester was not served last
                if (!rst) begin
                    grant0 = req0 & (~req1 | last);
                    grant1 = req1 & (~req0 | ~last);
                end
                if (grant0 | grant1) begin
                    last_nx  = grant1;
                    owner_nx = grant1;
                    shreg_nx = grant1 ? data1 : data0;
                    cnt_nx   = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                shreg_nx = shreg >> 1;
                if (cnt == WLAST) begin
                    cnt_nx   = '0;
                    state_nx = FLUSH;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            FLUSH: begin
                if (cnt == DLAST) begin
                    done     = 1'b1;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign sdo_vld = (state == SHIFT);
    assign sdo     = sdo_vld & shreg[0];
    assign busy    = (state != IDLE);
    assign owner   = owner_q;

endmodule

// File: tb/tb_siso_frame_sched.sv
// Scoreboard bench for siso_frame_sched: default instance with a model
// SISO chain, plus a WIDTH=8/DEPTH=2 instance.
module tb_siso_frame_sched;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [3:0] data0, data1;
    logic       grant0, grant1, sdo, sdo_vld, busy, done, owner;

    logic       r0b, r1b;
    logic [7:0] d0b, d1b;
    logic       g0b, g1b, sdob, vldb, busyb, doneb, ownerb;

    int vecs;
    int errs;
    bit sbq[$];
    bit qq[$];
    bit sbq2[$];

    logic [3:0] ch, chv;

    siso_frame_sched #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .grant0(grant0), .grant1(grant1), .sdo(sdo), .sdo_vld(sdo_vld),
        .busy(busy), .done(done), .owner(owner)
    );

    siso_frame_sched #(.WIDTH(8), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .req0(r0b), .data0(d0b), .req1(r1b), .data1(d1b),
        .grant0(g0b), .grant1(g1b), .sdo(sdob), .sdo_vld(vldb),
        .busy(busyb), .done(doneb), .owner(ownerb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model of the downstream 4-stage chain, with a valid tag alongside
    always @(posedge clk) begin
        if (rst) begin
            ch  <= '0;
            chv <= '0;
        end else begin
            ch  <= {ch[2:0], sdo};
            chv <= {chv[2:0], sdo_vld};
        end
    end

    always @(negedge clk) begin
        bit e;
        if (sdo_vld) begin
            vecs++;
            if (sbq.size() == 0) begin
                errs++;
                $display("FAIL sdo_extra: sdo=%0b with no bit expected", sdo);
            end else begin
                e = sbq.pop_front();
                if (sdo !== e) begin
                    errs++;
                    $display("FAIL sdo_bit: got %0b want %0b", sdo, e);
                end
            end
        end
        if (chv[3]) begin
            vecs++;
            if (qq.size() == 0) begin
                errs++;
                $display("FAIL q_extra: q=%0b with no bit expected", ch[3]);
            end else begin
                e = qq.pop_front();
                if (ch[3] !== e) begin
                    errs++;
                    $display("FAIL chain_q: got %0b want %0b", ch[3], e);
                end
            end
        end
        if (vldb) begin
            vecs++;
            if (sbq2.size() == 0) begin
                errs++;
                $display("FAIL sdo2_extra: sdo=%0b with no bit expected", sdob);
            end else begin
                e = sbq2.pop_front();
                if (sdob !== e) begin
                    errs++;
                    $display("FAIL sdo2_bit: got %0b want %0b", sdob, e);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [6:0] a;
        rst = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        data0 = 4'hF;
        data1 = 4'hF;
        @(negedge clk);
        vecs++;
        if ({grant0, grant1} !== 2'b00) begin
            errs++;
            $display("FAIL rst_grant: got %b want 00", {grant0, grant1});
        end
        tick;
        @(negedge clk);
        a = {grant0, grant1, busy, sdo, sdo_vld, done, owner};
        vecs++;
        if (a !== 7'b0) begin
            errs++;
            $display("FAIL rst_state: got %b want 0000000", a);
        end
        vecs++;
        if ({g0b, g1b, busyb, sdob, vldb, doneb, ownerb} !== 7'b0) begin
            errs++;
            $display("FAIL rst_state2: got %b want 0000000",
                     {g0b, g1b, busyb, sdob, vldb, doneb, ownerb});
        end
        rst = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        tick;
    endtask

    task automatic test_single;
        logic [4:0] e, a;
        data0 = 4'b1011;
        req0 = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            e = {c == 0, 1'b0, c >= 1 && c <= 8, c >= 1 && c <= 4, c == 8};
            a = {grant0, grant1, busy, sdo_vld, done};
            vecs++;
            if (a !== e) begin
                errs++;
                $display("FAIL single c=%0d: got %b want %b", c, a, e);
            end
            if (c >= 5 && c <= 8) begin
                vecs++;
                if (sdo !== 1'b0) begin
                    errs++;
                    $display("FAIL single_flush c=%0d: sdo=%b want 0", c, sdo);
                end
            end
            if (c == 0) begin
                for (int i = 0; i < 4; i++) begin
                    sbq.push_back(data0[i]);
                    qq.push_back(data0[i]);
                end
            end
            tick;
            if (c == 0) begin
                req0 = 1'b0;
                data0 = 4'h0;
            end
        end
    endtask

    task automatic test_tie;
        logic [4:0] e, a;
        int g, m;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        data0 = 4'hA;
        data1 = 4'h5;
        for (int c = 0; c <= 36; c++) begin
            req0 = (c < 36);
            req1 = (c < 36);
            g = (c / 9) % 2;
            m = c % 9;
            @(negedge clk);
            e = {m == 0 && c < 36 && g == 0, m == 0 && c < 36 && g == 1,
                 m != 0, m >= 1 && m <= 4, m == 8};
            a = {grant0, grant1, busy, sdo_vld, done};
            vecs++;
            if (a !== e) begin
                errs++;
                $display("FAIL tie c=%0d: got %b want %b", c, a, e);
            end
            if (m != 0) begin
                vecs++;
                if (owner !== g[0]) begin
                    errs++;
                    $display("FAIL tie_owner c=%0d: got %b want %b", c, owner, g[0]);
                end
            end
            if (m == 0 && c < 36) begin
                for (int i = 0; i < 4; i++) begin
                    sbq.push_back(g == 0 ? data0[i] : data1[i]);
                    qq.push_back(g == 0 ? data0[i] : data1[i]);
                end
            end
            tick;
        end
    endtask

    task automatic test_busy;
        logic [4:0] e, a;
        data0 = 4'h3;
        data1 = 4'hC;
        for (int c = 0; c <= 18; c++) begin
            req0 = (c == 0);
            req1 = (c >= 2 && c <= 9);
            @(negedge clk);
            e = {c == 0, c == 9, c != 0 && c != 9 && c != 18,
                 (c >= 1 && c <= 4) || (c >= 10 && c <= 13),
                 c == 8 || c == 17};
            a = {grant0, grant1, busy, sdo_vld, done};
            vecs++;
            if (a !== e) begin
                errs++;
                $display("FAIL busy c=%0d: got %b want %b", c, a, e);
            end
            if (c >= 10 && c <= 17) begin
                vecs++;
                if (owner !== 1'b1) begin
                    errs++;
                    $display("FAIL busy_owner c=%0d: got %b want 1", c, owner);
                end
            end
            if (c == 0 || c == 9) begin
                for (int i = 0; i < 4; i++) begin
                    sbq.push_back(c == 0 ? data0[i] : data1[i]);
                    qq.push_back(c == 0 ? data0[i] : data1[i]);
                end
            end
            tick;
        end
        req1 = 1'b0;
    endtask

    task automatic test_midreset;
        logic [4:0] e, a;
        for (int c = 0; c <= 13; c++) begin
            req0 = (c == 0 || c == 4);
            data0 = (c == 0) ? 4'h6 : 4'h9;
            rst = (c == 3);
            @(negedge clk);
            e = {c == 0 || c == 4, 1'b0,
                 (c >= 1 && c <= 3) || (c >= 5 && c <= 12),
                 (c >= 1 && c <= 3) || (c >= 5 && c <= 8), c == 12};
            a = {grant0, grant1, busy, sdo_vld, done};
            vecs++;
            if (a !== e) begin
                errs++;
                $display("FAIL midrst c=%0d: got %b want %b", c, a, e);
            end
            if (c == 4) begin
                vecs++;
                if (sdo !== 1'b0) begin
                    errs++;
                    $display("FAIL midrst_sdo: got %b want 0", sdo);
                end
            end
            if (c == 0) begin
                for (int i = 0; i < 3; i++) sbq.push_back(data0[i]);
            end
            if (c == 4) begin
                for (int i = 0; i < 4; i++) begin
                    sbq.push_back(data0[i]);
                    qq.push_back(data0[i]);
                end
            end
            tick;
        end
        rst = 1'b0;
        req0 = 1'b0;
    endtask

    task automatic test_data_change;
        logic [4:0] e, a;
        for (int c = 0; c <= 9; c++) begin
            req0 = (c == 0);
            data0 = (c == 0) ? 4'hF : 4'h0;
            @(negedge clk);
            e = {c == 0, 1'b0, c >= 1 && c <= 8, c >= 1 && c <= 4, c == 8};
            a = {grant0, grant1, busy, sdo_vld, done};
            vecs++;
            if (a !== e) begin
                errs++;
                $display("FAIL datachg c=%0d: got %b want %b", c, a, e);
            end
            if (c == 0) begin
                for (int i = 0; i < 4; i++) begin
                    sbq.push_back(1'b1);
                    qq.push_back(1'b1);
                end
            end
            tick;
        end
    endtask

    task automatic test_sweep;
        logic [4:0] e, a;
        d0b = 8'h96;
        for (int c = 0; c <= 22; c++) begin
            r0b = (c <= 11);
            @(negedge clk);
            e = {c == 0 || c == 11, 1'b0,
                 (c >= 1 && c <= 10) || (c >= 12 && c <= 21),
                 (c >= 1 && c <= 8) || (c >= 12 && c <= 19),
                 c == 10 || c == 21};
            a = {g0b, g1b, busyb, vldb, doneb};
            vecs++;
            if (a !== e) begin
                errs++;
                $display("FAIL sweep c=%0d: got %b want %b", c, a, e);
            end
            if (c == 0 || c == 11) begin
                for (int i = 0; i < 8; i++) sbq2.push_back(d0b[i]);
            end
            tick;
        end
        r0b = 1'b0;
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        data0 = '0;
        data1 = '0;
        r0b = 1'b0;
        r1b = 1'b0;
        d0b = '0;
        d1b = '0;
        tick;
        test_reset;
        test_single;
        test_tie;
        test_busy;
        test_midreset;
        test_data_change;
        test_sweep;
        repeat (6) tick;
        vecs++;
        if (sbq.size() + qq.size() + sbq2.size() != 0) begin
            errs++;
            $display("FAIL leftover: %0d/%0d/%0d bits pending want 0",
                     sbq.size(), qq.size(), sbq2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
